// File: rtl/axi_mem_model.sv
// ----------------------------------------------------------------------------
// axi_mem_model: AXI4 INCR-burst memory model with fixed read latency.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axi_mem_model #(
   parameter int ADDR_BITS    = 32,
   parameter int DATA_BITS    = 64,
   parameter int ID_BITS      = 5,
   parameter int MEM_WORDS    = 4096,
   parameter int READ_LATENCY = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   aw_valid,
   output logic                   aw_ready,
   input  logic [ADDR_BITS-1:0]   aw_addr,
   input  logic [7:0]             aw_len,
   input  logic [ID_BITS-1:0]     aw_id,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [DATA_BITS-1:0]   w_data,
   input  logic [DATA_BITS/8-1:0] w_strb,
   input  logic                   w_last,
   output logic                   b_valid,
   input  logic                   b_ready,
   output logic [1:0]             b_resp,
   output logic [ID_BITS-1:0]     b_id,
   input  logic                   ar_valid,
   output logic                   ar_ready,
   input  logic [ADDR_BITS-1:0]   ar_addr,
   input  logic [7:0]             ar_len,
   input  logic [ID_BITS-1:0]     ar_id,
   output logic                   r_valid,
   input  logic                   r_ready,
   output logic [DATA_BITS-1:0]   r_data,
   output logic [1:0]             r_resp,
   output logic                   r_last,
   output logic [ID_BITS-1:0]     r_id
);

   localparam int                   c_STRB_BITS   = DATA_BITS / 8;
   localparam int                   c_OFFS_BITS   = $clog2(c_STRB_BITS);
   localparam int                   c_MEM_AW      = $clog2(MEM_WORDS);
   localparam logic [ADDR_BITS-1:0] c_MEM_WORDS   = ADDR_BITS'(MEM_WORDS);
   localparam logic [3:0]           c_WAIT_CYCLES = 4'(READ_LATENCY - 1);
   localparam logic [1:0]           c_OKAY        = 2'b00;
   localparam logic [1:0]           c_SLVERR      = 2'b10;
   localparam logic [1:0]           c_DECERR      = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;

   logic [DATA_BITS-1:0] mem_q [MEM_WORDS];

   wstate_t              wstate_q;
   logic                 aw_ready_q, w_ready_q, b_valid_q, wr_oor_q;
   logic [1:0]           b_resp_q;
   logic [ID_BITS-1:0]   b_id_q;
   logic [ADDR_BITS-1:0] wr_idx_q;
   logic [7:0]           wr_len_q;
   logic [8:0]           wr_cnt_q;

   rstate_t              rstate_q;
   logic                 ar_ready_q, r_valid_q, r_last_q;
   logic [DATA_BITS-1:0] r_data_q;
   logic [1:0]           r_resp_q;
   logic [ID_BITS-1:0]   r_id_q;
   logic [ADDR_BITS-1:0] rd_idx_q;
   logic [7:0]           rd_len_q, rd_beat_q;
   logic [3:0]           wait_q;

   logic [ADDR_BITS-1:0] aw_base, ar_base, ar_end, ld_idx;
   logic                 wr_beat, wr_in_range, wr_en, ar_oor, load;
   logic [7:0]           ld_beat, ld_len;
   logic [DATA_BITS-1:0] ld_data_d;

   assign aw_base     = aw_addr >> c_OFFS_BITS;
   assign ar_base     = ar_addr >> c_OFFS_BITS;
   assign ar_end      = ar_base + ADDR_BITS'(ar_len);
   assign ar_oor      = (ar_end >= c_MEM_WORDS);
   assign wr_beat     = w_valid & w_ready_q;
   assign wr_in_range = (wr_idx_q < c_MEM_WORDS);
   assign wr_en       = wr_beat & wr_in_range & ~reset;

   // Memory storage is deliberately not reset so contents survive a reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < c_STRB_BITS; b++) begin
            if (w_strb[b]) begin
               mem_q[wr_idx_q[c_MEM_AW-1:0]][b*8 +: 8] <= w_data[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wstate_q   <= W_IDLE;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (aw_valid && aw_ready_q) begin
                  wstate_q   <= W_DATA;
                  aw_ready_q <= 1'b0;
                  w_ready_q  <= 1'b1;
                  b_id_q     <= aw_id;
                  wr_idx_q   <= aw_base;
                  wr_len_q   <= aw_len;
                  wr_cnt_q   <= '0;
                  wr_oor_q   <= 1'b0;
               end else begin
                  aw_ready_q <= 1'b1;
               end
            end
            W_DATA: begin
               if (wr_beat) begin
                  wr_idx_q <= wr_idx_q + ADDR_BITS'(1);
                  if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 9'd1;
                  wr_oor_q <= wr_oor_q | ~wr_in_range;
                  if (w_last) begin
                     wstate_q  <= W_RESP;
                     w_ready_q <= 1'b0;
                     b_valid_q <= 1'b1;
                     // wr_cnt_q still holds the count before this final beat
                     if (wr_cnt_q != {1'b0, wr_len_q}) b_resp_q <= c_SLVERR;
                     else if (wr_oor_q || !wr_in_range) b_resp_q <= c_DECERR;
                     else b_resp_q <= c_OKAY;
                  end
               end
            end
            W_RESP: begin
               if (b_ready) begin
                  wstate_q   <= W_IDLE;
                  b_valid_q  <= 1'b0;
                  aw_ready_q <= 1'b1;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // Next beat source: straight from the AR channel when loading at acceptance.
   assign ld_idx  = (rstate_q == R_IDLE) ? ar_base : rd_idx_q;
   assign ld_beat = (rstate_q == R_IDLE) ? 8'd0    : rd_beat_q;
   assign ld_len  = (rstate_q == R_IDLE) ? ar_len  : rd_len_q;

   assign load = ((rstate_q == R_IDLE) && ar_valid && ar_ready_q && (c_WAIT_CYCLES == 4'd0))
              || ((rstate_q == R_WAIT) && (wait_q == 4'd1))
              || ((rstate_q == R_BURST) && r_valid_q && r_ready && !r_last_q);

   // Write-first: a beat loaded on the same edge as a write to its word sees the new bytes.
   always_comb begin
      ld_data_d = mem_q[ld_idx[c_MEM_AW-1:0]];
      if (wr_en && (wr_idx_q == ld_idx)) begin
         for (int b = 0; b < c_STRB_BITS; b++) begin
            if (w_strb[b]) ld_data_d[b*8 +: 8] = w_data[b*8 +: 8];
         end
      end
      if (ld_idx >= c_MEM_WORDS) ld_data_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rstate_q   <= R_IDLE;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_valid && ar_ready_q) begin
                  ar_ready_q <= 1'b0;
                  r_id_q     <= ar_id;
                  r_resp_q   <= ar_oor ? c_DECERR : c_OKAY;
                  rd_len_q   <= ar_len;
                  rd_idx_q   <= ar_base;
                  rd_beat_q  <= 8'd0;
                  wait_q     <= c_WAIT_CYCLES;
                  if (c_WAIT_CYCLES == 4'd0) begin
                     rstate_q  <= R_BURST;
                     r_valid_q <= 1'b1;
                  end else begin
                     rstate_q <= R_WAIT;
                  end
               end else begin
                  ar_ready_q <= 1'b1;
               end
            end
            R_WAIT: begin
               if (wait_q == 4'd1) begin
                  rstate_q  <= R_BURST;
                  r_valid_q <= 1'b1;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            R_BURST: begin
               if (r_valid_q && r_ready && r_last_q) begin
                  rstate_q   <= R_IDLE;
                  r_valid_q  <= 1'b0;
                  ar_ready_q <= 1'b1;
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
         if (load) begin
            r_data_q  <= ld_data_d;
            r_last_q  <= (ld_beat == ld_len);
            rd_idx_q  <= ld_idx + ADDR_BITS'(1);
            rd_beat_q <= ld_beat + 8'd1;
         end
      end
   end

   assign aw_ready = aw_ready_q;
   assign w_ready  = w_ready_q;
   assign b_valid  = b_valid_q;
   assign b_resp   = b_resp_q;
   assign b_id     = b_id_q;
   assign ar_ready = ar_ready_q;
   assign r_valid  = r_valid_q;
   assign r_data   = r_data_q;
   assign r_resp   = r_resp_q;
   assign r_last   = r_last_q;
   assign r_id     = r_id_q;

endmodule

`default_nettype wire

// File: doc/axi_mem_model.md
AXI_MEM_MODEL -- requirements
Module: axi_mem_model

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_BITS, default 64: beat width, power of two, 32..512.
REQ-003 SHALL have parameter ID_BITS, default 5: transaction ID width.
REQ-004 SHALL have parameter MEM_WORDS, default 4096: storage depth in DATA_BITS words, power of two.
REQ-005 SHALL have parameter READ_LATENCY, default 4: cycles from AR acceptance to the first R beat valid, range 1..16.
REQ-006 SHALL have ports clock in 1 (rising edge) and reset in 1 (synchronous, active-high).
REQ-007 SHALL have AW ports: aw_valid in 1, aw_ready out 1, aw_addr in ADDR_BITS, aw_len in 8 (beats-1), aw_id in ID_BITS.
REQ-008 SHALL have W ports: w_valid in 1, w_ready out 1, w_data in DATA_BITS, w_strb in DATA_BITS/8, w_last in 1.
REQ-009 SHALL have B ports: b_valid out 1, b_ready in 1, b_resp out 2, b_id out ID_BITS.
REQ-010 SHALL have AR ports: ar_valid in 1, ar_ready out 1, ar_addr in ADDR_BITS, ar_len in 8, ar_id in ID_BITS.
REQ-011 SHALL have R ports: r_valid out 1, r_ready in 1, r_data out DATA_BITS, r_resp out 2, r_last out 1, r_id out ID_BITS.

Function
REQ-012 SHALL implement all bursts as INCR with full-width beats; word index = (addr >> log2(DATA_BITS/8)) + beat, with the low address bits ignored.
REQ-013 SHALL treat a beat whose word index >= MEM_WORDS as out of range: writes dropped, read data 0, burst response 2'b11 (DECERR).
REQ-014 SHALL run the write FSM as W_IDLE -> W_DATA -> W_RESP -> W_IDLE; aw_ready=1 only in W_IDLE, w_ready=1 only in W_DATA, b_valid=1 only in W_RESP.
REQ-015 SHALL write each accepted W beat in the same cycle, byte-masked by w_strb; w_strb=0 leaves the word unchanged.
REQ-016 SHALL leave W_DATA on the accepted beat with w_last=1; if beat count != aw_len+1 at that point, b_resp = 2'b10 (SLVERR), otherwise OKAY unless any beat was out of range.
REQ-017 SHALL hold b_valid, b_resp and b_id stable until b_ready, then return to W_IDLE; aw_ready is reasserted the next cycle.
REQ-018 SHALL run the read FSM as R_IDLE -> R_WAIT -> R_BURST -> R_IDLE; ar_ready=1 only in R_IDLE.
REQ-019 SHALL count READ_LATENCY-1 cycles in R_WAIT, then assert r_valid in R_BURST.
REQ-020 SHALL hold r_data, r_resp, r_last and r_id stable while r_valid=1 and r_ready=0, and advance the beat only on r_valid & r_ready.
REQ-021 SHALL assert r_last on beat ar_len; after that handshake, return to R_IDLE and reassert ar_ready the next cycle.
REQ-022 SHALL allow read and write FSMs to run concurrently.
REQ-023 SHALL resolve a same-cycle read and write to one word as write-first: the R beat presented that cycle shows the old data, later beats show the new data.
REQ-024 SHALL echo aw_id on b_id and ar_id on r_id, captured at AW/AR acceptance.
REQ-025 SHALL support aw_len and ar_len up to 255, with the word index wrapping modulo 2^ADDR_BITS and no other wrap.

Reset
REQ-026 SHALL, while reset=1, drive aw_ready, w_ready, b_valid, ar_ready and r_valid to 0, force both FSMs to IDLE, and abort any in-flight burst without a response.
REQ-027 SHALL preserve memory contents across reset; ready outputs SHALL rise one cycle after reset deasserts.

Verification
REQ-028 SHALL pass: AW addr 0x40 len 3 id 5, four W beats 0x11..0x44 with strb all ones -> b_resp 0, b_id 5; AR same -> 4 R beats 0x11..0x44, r_last on beat 4, first r_valid READ_LATENCY cycles after AR.
REQ-029 SHALL pass: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with strb 8'h0F, read back -> 0xFFFF_FFFF_0000_0000.
REQ-030 SHALL pass: AR at word MEM_WORDS-1 len 1 -> beat 1 data 0, r_resp 2'b11 on the burst.
REQ-031 SHALL pass: aw_len 3 with w_last on beat 2 -> b_resp 2'b10; the next AW is accepted normally.
REQ-032 SHALL pass: r_ready held low 10 cycles mid-burst -> R outputs stable, no beat lost or duplicated.
REQ-033 SHALL pass: reset asserted during R_BURST -> r_valid 0 next cycle, ar_ready 1 one cycle after release, earlier memory data intact.
